div_64bit: RTL and testbench
============================

DIV_64BIT -- requirements
Module: div_64bit

Interface
REQ-001 SHALL have no parameters; width is fixed at 64 bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous assert, active-high.
REQ-004 in_valid  input  1  operand request valid.
REQ-005 in_ready  output  1  divider idle and accepting operands.
REQ-006 dividend  input  64  numerator.
REQ-007 divisor  input  64  denominator.
REQ-008 alu32  input  1  1 = 32-bit operation on low halves (eBPF ALU class); 0 = 64-bit.
REQ-009 abort  input  1  synchronous cancel of the in-flight operation.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 quotient  output  64  division result.
REQ-013 remainder  output  64  modulo result.
REQ-014 signed_op  input  1  signed division select; present only when DIV_64BIT_SIGNED_EN is defined.

Function
REQ-015 States SHALL be IDLE, CALC, DONE; in_ready = (state==IDLE), out_valid = (state==DONE).
REQ-016 Transfer in SHALL occur on in_valid & in_ready; operands, alu32 and signed_op are captured at that edge.
REQ-017 Radix-2 restoring algorithm: one quotient bit per cycle, N = 64 iterations (alu32=0) or 32 iterations (alu32=1).
REQ-018 Accept at edge T: state = CALC for N cycles, out_valid SHALL first be high in cycle T+N+1.
REQ-019 Divisor zero (after alu32 masking): skip CALC, go to DONE at T+1, quotient = 0, remainder = dividend (masked).
REQ-020 alu32=1: only bits [31:0] of operands are used; quotient and remainder SHALL be zero-extended to 64 bits.
REQ-021 DONE SHALL hold quotient/remainder stable until out_valid & out_ready, then return to IDLE the next cycle; no back-to-back accept in that same edge.
REQ-022 abort in CALC or DONE SHALL return to IDLE on the next edge, discard the result, and emit no out_valid; abort in IDLE is ignored.
REQ-023 abort and out_ready asserted together in DONE SHALL be treated as a normal handshake (result counts as delivered).
REQ-024 Operand inputs SHALL be ignored while not in IDLE.

Reset
REQ-025 rst SHALL force state IDLE, in_ready=1 after release, out_valid=0, quotient=0, remainder=0, iteration counter=0.
REQ-026 rst during CALC or DONE SHALL discard the operation; no out_valid after release until a new accept.

Configuration
REQ-027 With DIV_64BIT_SIGNED_EN defined, signed_op=1 SHALL divide two's-complement values: quotient truncated toward zero, remainder takes sign of dividend.
REQ-028 Signed overflow (INT_MIN / -1 at the selected width) SHALL give quotient = INT_MIN, remainder = 0, through normal CALC latency.
REQ-029 Signed divide-by-zero SHALL follow REQ-019; 32-bit signed results SHALL still be zero-extended.
REQ-030 Without DIV_64BIT_SIGNED_EN, the signed_op port and sign logic SHALL be absent; all division unsigned.

Structure
REQ-031 Shared package div_pkg SHALL hold the state enum type, XLEN=64, HALF=32 constants and iteration-counter width.
REQ-032 One sub-module div_step SHALL implement the combinational single-iteration shift/subtract/restore; div_64bit holds FSM, counter, sign fix-up and handshake.

Verification
REQ-033 64-bit: dividend=100, divisor=7, alu32=0 -> quotient=14, remainder=2, out_valid at T+65.
REQ-034 32-bit: dividend=0xFFFF_FFFF_0000_000A, divisor=3, alu32=1 -> quotient=3, remainder=1, out_valid at T+33.
REQ-035 Divide by zero: dividend=0x1234, divisor=0 -> quotient=0, remainder=0x1234, out_valid at T+1.
REQ-036 Backpressure/abort: out_ready=0 for 10 cycles holds result stable; separate run with abort at CALC cycle 20 -> IDLE next cycle, no out_valid.
REQ-037 Signed (macro on): -7 / 2 -> quotient=-3, remainder=-1; 0x8000_0000_0000_0000 / -1 -> quotient=0x8000_0000_0000_0000, remainder=0.
REQ-038 Reset mid-CALC: assert rst at CALC cycle 30 -> out_valid=0, in_ready=1 after release, next 100/7 gives 14 remainder 2.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the 64-bit radix-2 restoring divider.
// Holds the FSM state type, operand widths and a low-half masking helper.
package div_pkg;
    localparam int XLEN  = 64;
    localparam int HALF  = 32;
    localparam int CNT_W = 7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    // Keep only the low half and zero-extend when the ALU32 class is selected.
    function automatic logic [XLEN-1:0] fit(input logic [XLEN-1:0] x, input logic a32);
        return a32 ? {{(XLEN-HALF){1'b0}}, x[HALF-1:0]} : x;
    endfunction
endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial subtract, restore.
// Purely combinational; the caller registers the partial remainder and quotient.
module div_step
    import div_pkg::*;
(
    input  logic [XLEN-1:0] i_rem,
    input  logic [XLEN-1:0] i_quo,
    input  logic [XLEN-1:0] i_den,
    output logic [XLEN-1:0] o_rem,
    output logic [XLEN-1:0] o_quo
);
    logic [XLEN-1:0] w_shift;
    logic            w_ge;

    // i_rem[MSB] is the bit shifted out; if set, the 65-bit trial value always exceeds i_den.
    assign w_shift = {i_rem[XLEN-2:0], i_quo[XLEN-1]};
    assign w_ge    = i_rem[XLEN-1] | (w_shift >= i_den);
    assign o_rem   = w_ge ? (w_shift - i_den) : w_shift;
    assign o_quo   = {i_quo[XLEN-2:0], w_ge};
endmodule

// File: rtl/div_64bit.sv
// 64/32-bit iterative divider (one quotient bit per cycle); signed mode built with DIV_64BIT_SIGNED_EN.
// Latency: result valid N+1 cycles after accept (N = 64 or 32), one cycle for a zero divisor.
// Backpressure: result held in DONE until out_ready; abort drops the operation and returns to idle.
module div_64bit
    import div_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            alu32,
    input  logic            abort,
`ifdef DIV_64BIT_SIGNED_EN
    input  logic            signed_op,
`endif
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);
    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [XLEN-1:0]   r_rem;
    logic [XLEN-1:0]   r_quo;
    logic [XLEN-1:0]   r_den;
    logic              r_a32;
    logic [XLEN-1:0]   r_quotient;
    logic [XLEN-1:0]   r_remainder;

    logic [XLEN-1:0]   w_dd_mag;
    logic [XLEN-1:0]   w_ds_mag;
    logic [XLEN-1:0]   w_rem_nxt;
    logic [XLEN-1:0]   w_quo_nxt;
    logic [XLEN-1:0]   w_q_fin;
    logic [XLEN-1:0]   w_r_fin;

`ifdef DIV_64BIT_SIGNED_EN
    logic              r_q_neg;
    logic              r_r_neg;
    logic              w_dd_neg;
    logic              w_ds_neg;

    // Divide magnitudes, then restore signs: quotient truncates toward zero, remainder follows dividend.
    always_comb begin
        w_dd_neg = signed_op & (alu32 ? dividend[HALF-1] : dividend[XLEN-1]);
        w_ds_neg = signed_op & (alu32 ? divisor[HALF-1]  : divisor[XLEN-1]);
        w_dd_mag = w_dd_neg ? fit(-dividend, alu32) : fit(dividend, alu32);
        w_ds_mag = w_ds_neg ? fit(-divisor, alu32)  : fit(divisor, alu32);
        w_q_fin  = r_q_neg ? fit(-w_quo_nxt, r_a32) : w_quo_nxt;
        w_r_fin  = r_r_neg ? fit(-w_rem_nxt, r_a32) : w_rem_nxt;
    end
`else
    always_comb begin
        w_dd_mag = fit(dividend, alu32);
        w_ds_mag = fit(divisor, alu32);
        w_q_fin  = w_quo_nxt;
        w_r_fin  = w_rem_nxt;
    end
`endif

    div_step u_step (
        .i_rem (r_rem),
        .i_quo (r_quo),
        .i_den (r_den),
        .o_rem (w_rem_nxt),
        .o_quo (w_quo_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_den       <= '0;
            r_a32       <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
`ifdef DIV_64BIT_SIGNED_EN
            r_q_neg     <= 1'b0;
            r_r_neg     <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a32 <= alu32;
                        r_rem <= '0;
                        r_den <= w_ds_mag;
                        // 32-bit dividends sit in the top half so the same shift path serves both widths.
                        r_quo <= alu32 ? {w_dd_mag[HALF-1:0], {HALF{1'b0}}} : w_dd_mag;
`ifdef DIV_64BIT_SIGNED_EN
                        r_q_neg <= w_dd_neg ^ w_ds_neg;
                        r_r_neg <= w_dd_neg;
`endif
                        if (w_ds_mag == '0) begin
                            r_quotient  <= '0;
                            r_remainder <= fit(dividend, alu32);
                            r_state     <= S_DONE;
                        end else begin
                            r_cnt   <= alu32 ? CNT_W'(HALF) : CNT_W'(XLEN);
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (abort) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_rem <= w_rem_nxt;
                        r_quo <= w_quo_nxt;
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == CNT_W'(1)) begin
                            r_quotient  <= w_q_fin;
                            r_remainder <= w_r_fin;
                            r_state     <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready || abort) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign quotient  = r_quotient;
    assign remainder = r_remainder;
endmodule

// File: tb/tb_div_64bit.sv
// Self-checking bench for div_64bit: directed vector table, random vectors against an
// arithmetic reference model, plus hand sequences for backpressure, abort and reset.
module tb_div_64bit;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] dividend;
    logic [63:0] divisor;
    logic        alu32;
    logic        abort;
    logic        signed_op;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] quotient;
    logic [63:0] remainder;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [63:0] dd;
        logic [63:0] ds;
        logic        a32;
        logic        sop;
        logic [63:0] q;
        logic [63:0] r;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    div_64bit dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .alu32     (alu32),
        .abort     (abort),
`ifdef DIV_64BIT_SIGNED_EN
        .signed_op (signed_op),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic at the selected width; lat = edges after accept before out_valid.
    function automatic vec_t model(input logic [63:0] dd, input logic [63:0] ds,
                                   input logic a32, input logic sop);
        vec_t   v;
        int     sa, sb;
        longint la, lb;
        v.dd = dd; v.ds = ds; v.a32 = a32; v.sop = sop;
        if (a32) begin
            v.lat = 32;
            if (ds[31:0] == 32'd0) begin
                v.q = 64'd0; v.r = {32'd0, dd[31:0]}; v.lat = 0;
            end else if (!sop) begin
                v.q = {32'd0, dd[31:0] / ds[31:0]};
                v.r = {32'd0, dd[31:0] % ds[31:0]};
            end else if (dd[31:0] == 32'h8000_0000 && ds[31:0] == 32'hFFFF_FFFF) begin
                v.q = 64'h0000_0000_8000_0000; v.r = 64'd0;
            end else begin
                sa = $signed(dd[31:0]);
                sb = $signed(ds[31:0]);
                v.q = {32'd0, 32'(sa / sb)};
                v.r = {32'd0, 32'(sa % sb)};
            end
        end else begin
            v.lat = 64;
            if (ds == 64'd0) begin
                v.q = 64'd0; v.r = dd; v.lat = 0;
            end else if (!sop) begin
                v.q = dd / ds;
                v.r = dd % ds;
            end else if (dd == 64'h8000_0000_0000_0000 && ds == 64'hFFFF_FFFF_FFFF_FFFF) begin
                v.q = dd; v.r = 64'd0;
            end else begin
                la = $signed(dd);
                lb = $signed(ds);
                v.q = 64'(la / lb);
                v.r = 64'(la % lb);
            end
        end
        return v;
    endfunction

    task automatic start(input vec_t v);
        dividend  = v.dd;
        divisor   = v.ds;
        alu32     = v.a32;
        signed_op = v.sop;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        // Operand inputs must be ignored once the divider is busy.
        dividend  = {$urandom, $urandom};
        divisor   = {$urandom, $urandom};
        alu32     = 1'($urandom_range(0, 1));
        signed_op = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic run(input vec_t v, input string tag);
        int lat;
        int guard;
        guard = 0;
        while (!in_ready && guard < 200) begin
            tick();
            guard++;
        end
        start(v);
        wait_done(lat);
        check({tag, "_lat"}, 64'(lat), 64'(v.lat));
        check({tag, "_q"}, quotient, v.q);
        check({tag, "_r"}, remainder, v.r);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_release"}, {62'd0, in_ready, out_valid}, 64'd2);
    endtask

    initial begin
        vec_t v;
        vec_t v100;
        int   lat;
        int   seen;
        logic [63:0] ds;
        logic        sop;

        rst = 1'b1; in_valid = 1'b0; dividend = '0; divisor = '0;
        alu32 = 1'b0; abort = 1'b0; signed_op = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        check("reset_in_ready", {63'd0, in_ready}, 64'd1);
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_quotient", quotient, 64'd0);
        check("reset_remainder", remainder, 64'd0);
        rst = 1'b0;
        tick();

        v100 = '{64'd100, 64'd7, 1'b0, 1'b0, 64'd14, 64'd2, 64};
        vecs.push_back(v100);
        vecs.push_back('{64'hFFFF_FFFF_0000_000A, 64'd3, 1'b1, 1'b0, 64'd3, 64'd1, 32});
        vecs.push_back('{64'h1234, 64'd0, 1'b0, 1'b0, 64'd0, 64'h1234, 0});
        vecs.push_back('{64'hAAAA_0000_0000_1234, 64'hFFFF_FFFF_0000_0000, 1'b1, 1'b0, 64'd0, 64'h1234, 0});
        vecs.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64});
        vecs.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 64'd1, 64'd0, 64});
        vecs.push_back('{64'd0, 64'd5, 1'b0, 1'b0, 64'd0, 64'd0, 64});
        vecs.push_back('{64'd5, 64'd9, 1'b1, 1'b0, 64'd0, 64'd5, 32});
        vecs.push_back('{64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 64'd0, 64'h8000_0000_0000_0000, 64});
`ifdef DIV_64BIT_SIGNED_EN
        vecs.push_back('{64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 64});
        vecs.push_back('{64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 64'h8000_0000_0000_0000, 64'd0, 64});
        vecs.push_back('{64'h0000_0000_FFFF_FFF9, 64'd2, 1'b1, 1'b1, 64'h0000_0000_FFFF_FFFD, 64'h0000_0000_FFFF_FFFF, 32});
        vecs.push_back('{64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b1, 64'h0000_0000_8000_0000, 64'd0, 32});
        vecs.push_back('{64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 1'b1, 1'b1, 64'd0, 64'h0000_0000_FFFF_FFFB, 0});
        vecs.push_back('{64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 64});
`endif
        for (int i = 0; i < vecs.size(); i++) begin
            run(vecs[i], $sformatf("table%0d", i));
        end

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0:       ds = {$urandom, $urandom};
                1:       ds = 64'($urandom_range(1, 1000));
                2:       ds = 64'd0;
                default: ds = {32'd0, $urandom};
            endcase
`ifdef DIV_64BIT_SIGNED_EN
            sop = 1'($urandom_range(0, 1));
`else
            sop = 1'b0;
`endif
            v = model({$urandom, $urandom}, ds, 1'($urandom_range(0, 1)), sop);
            run(v, $sformatf("rand%0d", i));
        end

        // Backpressure: result must stay put while out_ready is low.
        start(v100);
        wait_done(lat);
        check("bp_lat", 64'(lat), 64'd64);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_valid", {63'd0, out_valid}, 64'd1);
            check("bp_q", quotient, 64'd14);
            check("bp_r", remainder, 64'd2);
        end
        out_ready = 1'b1; abort = 1'b1;
        tick();
        out_ready = 1'b0; abort = 1'b0;
        check("bp_abort_handshake_idle", {62'd0, in_ready, out_valid}, 64'd2);

        // Abort on the 20th CALC cycle.
        start(v100);
        repeat (19) tick();
        check("abort_busy", {63'd0, in_ready}, 64'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_idle", {62'd0, in_ready, out_valid}, 64'd2);
        seen = 0;
        repeat (80) begin
            tick();
            if (out_valid) seen++;
        end
        check("abort_no_valid", 64'(seen), 64'd0);

        // Abort while the result is waiting in DONE.
        start(v100);
        wait_done(lat);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_done_idle", {62'd0, in_ready, out_valid}, 64'd2);

        // Abort while idle must not block an accept on the same edge.
        dividend = 64'd100; divisor = 64'd7; alu32 = 1'b0; signed_op = 1'b0;
        in_valid = 1'b1; abort = 1'b1;
        tick();
        in_valid = 1'b0; abort = 1'b0;
        check("abort_idle_accepted", {63'd0, in_ready}, 64'd0);
        wait_done(lat);
        check("abort_idle_lat", 64'(lat), 64'd64);
        check("abort_idle_q", quotient, 64'd14);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset on the 30th CALC cycle.
        start(v100);
        repeat (29) tick();
        rst = 1'b1;
        #2;
        check("rst_mid_valid", {63'd0, out_valid}, 64'd0);
        check("rst_mid_q", quotient, 64'd0);
        check("rst_mid_r", remainder, 64'd0);
        tick();
        rst = 1'b0;
        tick();
        check("rst_release_idle", {62'd0, in_ready, out_valid}, 64'd2);
        run(v100, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
